// File: rtl/tag_bank_writer.sv
// tag_bank_writer
//   Write side of a 2-way cache tag bank. An allocate request (index, tag)
//   is looked up in both ways. A hit refreshes LRU. A miss fills the first
//   invalid way, or the LRU way when both ways are valid. The response
//   reports hit, the way used, and any evicted tag. Combinational read ports
//   expose both ways' tags and valid bits at rd_index for the external
//   2-to-1 tag mux.
//
//   Request path : req_valid/req_ready, req_index, req_tag
//   Response path: resp_valid/resp_ready, resp_hit, resp_way, resp_evict,
//                  resp_evict_tag (held stable until accepted)
//   Control      : flush (honoured only while idle; clears valid and LRU)
//   Read side    : rd_index -> rd_tag0/rd_tag1, rd_valid0/rd_valid1
//
//   Optional build macro TAG_BANK_STATS_EN adds saturating 16-bit
//   hit_count/miss_count outputs. They are cleared by reset and by flush.
//
//   Sequence per request: IDLE -> LOOKUP -> WRITE -> RESP -> IDLE.
//   resp_valid rises after the third edge counting the acceptance edge.

module tag_bank_writer #(
  parameter int K     = 4,
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic [K-1:0]     req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic             resp_way,
  output logic             resp_evict,
  output logic [K-1:0]     resp_evict_tag,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_index,
  output logic [K-1:0]     rd_tag0,
  output logic [K-1:0]     rd_tag1,
  output logic             rd_valid0,
  output logic             rd_valid1
`ifdef TAG_BANK_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, RESP} state_t;

  state_t           state;

  logic [K-1:0]     tag0_mem [SETS];
  logic [K-1:0]     tag1_mem [SETS];
  logic [SETS-1:0]  valid0_mem;
  logic [SETS-1:0]  valid1_mem;
  logic [SETS-1:0]  lru_mem;     // way to victimise next when both ways valid

  logic [IDX_W-1:0] idx_q;
  logic [K-1:0]     tag_q;

  // Lookup results for the latched request
  logic             hit0, hit1;
  logic             lk_hit;
  logic             lk_way;
  logic             lk_evict;
  logic [K-1:0]     lk_evict_tag;

  assign req_ready = (state == IDLE) && !flush;

  assign rd_tag0   = tag0_mem[rd_index];
  assign rd_tag1   = tag1_mem[rd_index];
  assign rd_valid0 = valid0_mem[rd_index];
  assign rd_valid1 = valid1_mem[rd_index];

  always_comb begin
    hit0         = valid0_mem[idx_q] && (tag0_mem[idx_q] == tag_q);
    hit1         = valid1_mem[idx_q] && (tag1_mem[idx_q] == tag_q);
    lk_hit       = hit0 || hit1;
    lk_way       = 1'b0;
    lk_evict     = 1'b0;
    lk_evict_tag = '0;
    if (hit0) begin
      lk_way = 1'b0;
    end else if (hit1) begin
      lk_way = 1'b1;
    end else if (!valid0_mem[idx_q]) begin
      lk_way = 1'b0;
    end else if (!valid1_mem[idx_q]) begin
      lk_way = 1'b1;
    end else begin
      // Both ways valid and no hit: evict the LRU way
      lk_way       = lru_mem[idx_q];
      lk_evict     = 1'b1;
      lk_evict_tag = lru_mem[idx_q] ? tag1_mem[idx_q] : tag0_mem[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tag0_mem       <= '{default: '0};
      tag1_mem       <= '{default: '0};
      valid0_mem     <= '0;
      valid1_mem     <= '0;
      lru_mem        <= '0;
      idx_q          <= '0;
      tag_q          <= '0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_way       <= 1'b0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
`ifdef TAG_BANK_STATS_EN
      hit_count      <= '0;
      miss_count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid0_mem <= '0;
            valid1_mem <= '0;
            lru_mem    <= '0;
`ifdef TAG_BANK_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
          end else if (req_valid) begin
            idx_q <= req_index;
            tag_q <= req_tag;
            state <= LOOKUP;
          end
        end

        LOOKUP: begin
          resp_hit       <= lk_hit;
          resp_way       <= lk_way;
          resp_evict     <= lk_evict;
          resp_evict_tag <= lk_evict_tag;
`ifdef TAG_BANK_STATS_EN
          if (lk_hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end
`endif
          state <= WRITE;
        end

        WRITE: begin
          if (!resp_hit) begin
            if (resp_way) begin
              tag1_mem[idx_q]   <= tag_q;
              valid1_mem[idx_q] <= 1'b1;
            end else begin
              tag0_mem[idx_q]   <= tag_q;
              valid0_mem[idx_q] <= 1'b1;
            end
          end
          lru_mem[idx_q] <= ~resp_way;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_bank_writer.sv
// Directed bench for tag_bank_writer: a vector table of allocate requests
// with hand-computed responses and resulting array contents, followed by
// backpressure, flush and mid-operation reset sequences.

module tb_tag_bank_writer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_index;
  logic [3:0] req_tag;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_hit;
  logic       resp_way;
  logic       resp_evict;
  logic [3:0] resp_evict_tag;
  logic       flush;
  logic [2:0] rd_index;
  logic [3:0] rd_tag0;
  logic [3:0] rd_tag1;
  logic       rd_valid0;
  logic       rd_valid1;

  int checks = 0;
  int errors = 0;

  tag_bank_writer #(.K(4), .SETS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_index      (req_index),
    .req_tag        (req_tag),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_evict     (resp_evict),
    .resp_evict_tag (resp_evict_tag),
    .flush          (flush),
    .rd_index       (rd_index),
    .rd_tag0        (rd_tag0),
    .rd_tag1        (rd_tag1),
    .rd_valid0      (rd_valid0),
    .rd_valid1      (rd_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] tag;
    logic       hit;
    logic       way;
    logic       evict;
    logic [3:0] etag;
    logic [3:0] t0;
    logic [3:0] t1;
    logic       v0;
    logic       v1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request with resp_ready held high; returns captured response fields.
  task automatic run_req(input logic [2:0] idx, input logic [3:0] tag,
                         output logic h, output logic w, output logic e,
                         output logic [3:0] et);
    int lat;
    chk("req_ready_idle", req_ready, 1);
    req_index = idx;
    req_tag   = tag;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 2);
    h  = resp_hit;
    w  = resp_way;
    e  = resp_evict;
    et = resp_evict_tag;
    chk("req_ready_busy", req_ready, 0);
    @(posedge clk); #1;
    chk("resp_valid_drop", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       h, w, e;
    logic [3:0] et;
    logic       seen;
    int         lat;

    // idx tag | hit way evict etag | t0 t1 v0 v1 (array at idx afterwards)
    vecs[0]  = '{3'd3, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 4'h0, 1'b1, 1'b0};
    vecs[1]  = '{3'd3, 4'hB, 1'b0, 1'b1, 1'b0, 4'h0, 4'hA, 4'hB, 1'b1, 1'b1};
    vecs[2]  = '{3'd3, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, 4'hA, 4'hB, 1'b1, 1'b1};
    vecs[3]  = '{3'd3, 4'hC, 1'b0, 1'b1, 1'b1, 4'hB, 4'hA, 4'hC, 1'b1, 1'b1};
    vecs[4]  = '{3'd5, 4'h7, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 4'h0, 1'b1, 1'b0};
    vecs[5]  = '{3'd5, 4'h7, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 4'h0, 1'b1, 1'b0};
    vecs[6]  = '{3'd3, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, 4'hA, 4'hC, 1'b1, 1'b1};
    vecs[7]  = '{3'd3, 4'hD, 1'b0, 1'b1, 1'b1, 4'hC, 4'hA, 4'hD, 1'b1, 1'b1};
    vecs[8]  = '{3'd3, 4'hE, 1'b0, 1'b0, 1'b1, 4'hA, 4'hE, 4'hD, 1'b1, 1'b1};
    vecs[9]  = '{3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0};
    vecs[10] = '{3'd7, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[11] = '{3'd7, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_index  = '0;
    req_tag    = '0;
    resp_ready = 1'b1;
    flush      = 1'b0;
    rd_index   = '0;

    // Reset state
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_resp_evict", resp_evict, 0);
    chk("rst_resp_evict_tag", resp_evict_tag, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      rd_index = 3'(i);
      #1;
      chk($sformatf("rst_rd_valid0[%0d]", i), rd_valid0, 0);
      chk($sformatf("rst_rd_valid1[%0d]", i), rd_valid1, 0);
      chk($sformatf("rst_rd_tag0[%0d]", i), rd_tag0, 0);
      chk($sformatf("rst_rd_tag1[%0d]", i), rd_tag1, 0);
    end

    // Vector table
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].idx, vecs[i].tag, h, w, e, et);
      chk($sformatf("v%0d_hit", i), h, vecs[i].hit);
      chk($sformatf("v%0d_way", i), w, vecs[i].way);
      chk($sformatf("v%0d_evict", i), e, vecs[i].evict);
      chk($sformatf("v%0d_evict_tag", i), et, vecs[i].etag);
      rd_index = vecs[i].idx;
      #1;
      chk($sformatf("v%0d_rd_tag0", i), rd_tag0, vecs[i].t0);
      chk($sformatf("v%0d_rd_tag1", i), rd_tag1, vecs[i].t1);
      chk($sformatf("v%0d_rd_valid0", i), rd_valid0, vecs[i].v0);
      chk($sformatf("v%0d_rd_valid1", i), rd_valid1, vecs[i].v1);
    end

    // Backpressure; a flush pulse while busy must be ignored
    resp_ready = 1'b0;
    req_index  = 3'd2;
    req_tag    = 4'h9;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_hit", resp_hit, 0);
      chk("bp_resp_way", resp_way, 0);
      chk("bp_resp_evict", resp_evict, 0);
      chk("bp_resp_evict_tag", resp_evict_tag, 0);
      chk("bp_req_ready", req_ready, 0);
      flush = (i == 1);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_resp_valid", resp_valid, 0);
    chk("bp_release_req_ready", req_ready, 1);
    rd_index = 3'd2;
    #1;
    chk("bp_rd_valid0", rd_valid0, 1);
    chk("bp_rd_tag0", rd_tag0, 4'h9);
    rd_index = 3'd3;
    #1;
    chk("busy_flush_ignored_v1", rd_valid1, 1);

    // Flush in IDLE
    flush = 1'b1;
    #1;
    chk("flush_req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    rd_index = 3'd3;
    #1;
    chk("flush_rd_valid0", rd_valid0, 0);
    chk("flush_rd_valid1", rd_valid1, 0);
    run_req(3'd3, 4'hC, h, w, e, et);
    chk("post_flush_hit", h, 0);
    chk("post_flush_way", w, 0);
    chk("post_flush_evict", e, 0);
    chk("post_flush_evict_tag", et, 0);

    // Async reset during LOOKUP
    req_index = 3'd4;
    req_tag   = 4'h5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("midrst_no_resp", seen, 0);
    chk("midrst_req_ready", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      rd_index = 3'(i);
      #1;
      chk($sformatf("midrst_rd_valid0[%0d]", i), rd_valid0, 0);
      chk($sformatf("midrst_rd_valid1[%0d]", i), rd_valid1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
